// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, NOP word and default geometry.
// Optional build macro used by the fetch stage: FETCH_DELAY_SLOT_EN.
package instruction_fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD           = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_IMEM_WORDS = 128;

  // Fetch addresses are always word aligned; the low two target bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: decode-side controls, instruction memory port and IF/ID outputs.
interface instruction_fetch_if;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, halted, fetch_count
  );

endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: load a new fetch, hold on stall, or insert a bubble.
module instruction_fetch_if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  logic [31:0] instr_reg;
  logic [31:0] pc_plus4_reg;
  logic        valid_reg;

  // Bubble wins over load; neither asserted means hold.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      instr_reg    <= NOP_WORD;
      pc_plus4_reg <= 32'd0;
      valid_reg    <= 1'b0;
    end else if (load) begin
      instr_reg    <= instr_in;
      pc_plus4_reg <= pc_plus4_in;
      valid_reg    <= 1'b1;
    end
  end

  assign instr    = instr_reg;
  assign pc_plus4 = pc_plus4_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/instruction_fetch.sv
// PC register and RUN/HALT fetch FSM driving instruction memory and the IF/ID register.
// Build macro FETCH_DELAY_SLOT_EN keeps the in-flight fetch on redirect instead of squashing it.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  count_reg, count_next;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         pc_in_range;
  logic         target_in_range;
  logic         ifid_load;
  logic         ifid_bubble;

  assign pc_plus4        = pc_reg + 32'd4;
  assign target          = word_align(bus.redirect_pc);
  assign pc_in_range     = (pc_reg < PC_LIMIT);
  assign target_in_range = (target < PC_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    count_next  = count_reg;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    case (state_reg)
      RUN: begin
        if (bus.redirect) begin
          pc_next = target;
`ifdef FETCH_DELAY_SLOT_EN
          // The delay-slot word is kept unless it is off the end of memory.
          if (!pc_in_range) begin
            ifid_bubble = 1'b1;
          end else if (!bus.stall) begin
            ifid_load  = 1'b1;
            count_next = count_reg + 32'd1;
          end
`else
          ifid_bubble = 1'b1;
`endif
        end else if (!pc_in_range) begin
          // Running off the end halts even while decode is stalling.
          state_next  = HALT;
          ifid_bubble = 1'b1;
        end else if (!bus.stall) begin
          pc_next    = pc_plus4;
          ifid_load  = 1'b1;
          count_next = count_reg + 32'd1;
        end
      end
      HALT: begin
        ifid_bubble = 1'b1;
        if (bus.redirect && target_in_range) begin
          state_next = RUN;
          pc_next    = target;
        end
      end
      default: begin
        state_next  = RUN;
        ifid_bubble = 1'b1;
      end
    endcase
  end

  instruction_fetch_if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .instr_in   (bus.imem_instr),
    .pc_plus4_in(pc_plus4),
    .instr      (bus.if_id_instr),
    .pc_plus4   (bus.if_id_pc_plus4),
    .valid      (bus.if_id_valid)
  );

  assign bus.imem_addr   = pc_reg;
  assign bus.halted      = (state_reg == HALT);
  assign bus.fetch_count = count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed bench for instruction_fetch against a cycle-level behavioural model.
module tb_instruction_fetch;

  localparam int          IMEM_WORDS = 128;
  localparam logic [31:0] LIMIT      = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem [IMEM_WORDS];

  always_comb begin
    if (bus.imem_addr < LIMIT) bus.imem_instr = mem[bus.imem_addr[8:2]];
    else                       bus.imem_instr = 32'hFFFF_FFFF;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference state: what the fetch stage should look like after each edge.
  logic [31:0] m_pc, m_instr, m_pp4, m_count;
  logic        m_valid, m_halted, m_pp4_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_bubble();
    m_valid     = 1'b0;
    m_instr     = 32'h0;
    m_pp4_known = 1'b0;
  endtask

  task automatic model_fetch();
    m_instr     = mem[m_pc[8:2]];
    m_pp4       = m_pc + 32'd4;
    m_pp4_known = 1'b1;
    m_valid     = 1'b1;
    m_count     = m_count + 32'd1;
  endtask

  task automatic model_step(input logic r, input logic s, input logic d, input logic [31:0] t);
    logic [31:0] tgt;
    tgt = {t[31:2], 2'b00};
    if (r) begin
      m_pc = RESET_PC; m_count = 0; m_halted = 0;
      m_valid = 0; m_instr = 0; m_pp4 = 0; m_pp4_known = 1;
    end else if (m_halted) begin
      model_bubble();
      if (d && tgt < LIMIT) begin
        m_halted = 0;
        m_pc     = tgt;
      end
    end else if (d) begin
`ifdef FETCH_DELAY_SLOT_EN
      if (m_pc >= LIMIT) model_bubble();
      else if (!s)       model_fetch();
`else
      model_bubble();
`endif
      m_pc = tgt;
    end else if (m_pc >= LIMIT) begin
      m_halted = 1;
      model_bubble();
    end else if (!s) begin
      model_fetch();
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic do_cycle(input logic r, input logic s, input logic d, input logic [31:0] t);
    @(negedge clk);
    reset           = r;
    bus.stall       = s;
    bus.redirect    = d;
    bus.redirect_pc = t;
    model_step(r, s, d, t);
    @(posedge clk);
    #1;
    cyc++;
    check("imem_addr", bus.imem_addr, m_pc);
    check("halted", 32'(bus.halted), 32'(m_halted));
    check("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
    check("if_id_instr", bus.if_id_instr, m_instr);
    check("fetch_count", bus.fetch_count, m_count);
    if (m_pp4_known) check("if_id_pc_plus4", bus.if_id_pc_plus4, m_pp4);
    $display("cyc %0d rst=%0b stall=%0b redir=%0b tgt=%h | addr=%h v=%0b instr=%h pc4=%h halt=%0b cnt=%0d",
             cyc, r, s, d, t, bus.imem_addr, bus.if_id_valid, bus.if_id_instr,
             bus.if_id_pc_plus4, bus.halted, bus.fetch_count);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, bus.imem_addr, RESET_PC);
    check({tag, "_instr"}, bus.if_id_instr, 32'h0);
    check({tag, "_pc4"}, bus.if_id_pc_plus4, 32'h0);
    check({tag, "_valid"}, 32'(bus.if_id_valid), 32'h0);
    check({tag, "_halted"}, 32'(bus.halted), 32'h0);
    check({tag, "_count"}, bus.fetch_count, 32'h0);
  endtask

  initial begin
    logic        r, s, d;
    logic [31:0] t;
    int          guard;

    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h2002_0005;
    mem[1] = 32'h2003_000c;
    reset = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    m_pc = 0; m_count = 0; m_halted = 0; m_valid = 0; m_instr = 0; m_pp4 = 0; m_pp4_known = 1;

    do_cycle(1, 0, 0, 0);
    check_reset_values("reset");

    // Free run from reset.
    do_cycle(0, 0, 0, 0);
    check("run1_addr", bus.imem_addr, 32'd4);
    check("run1_instr", bus.if_id_instr, 32'h2002_0005);
    check("run1_pc4", bus.if_id_pc_plus4, 32'd4);
    check("run1_count", bus.fetch_count, 32'd1);
    do_cycle(0, 0, 0, 0);
    check("run2_addr", bus.imem_addr, 32'd8);
    check("run2_instr", bus.if_id_instr, 32'h2003_000c);
    check("run2_count", bus.fetch_count, 32'd2);

    // Two-cycle stall at pc=8.
    do_cycle(0, 1, 0, 0);
    do_cycle(0, 1, 0, 0);
    check("stall_addr", bus.imem_addr, 32'd8);
    check("stall_instr", bus.if_id_instr, 32'h2003_000c);
    check("stall_count", bus.fetch_count, 32'd2);
    do_cycle(0, 0, 0, 0);
    check("resume_addr", bus.imem_addr, 32'd12);

    // Advance to pc=0x18, then redirect to an unaligned target.
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0);
    check("pre_redir_addr", bus.imem_addr, 32'h18);
    do_cycle(0, 0, 1, 32'h3E);
    check("redir_addr", bus.imem_addr, 32'h3C);
`ifdef FETCH_DELAY_SLOT_EN
    check("redir_slot_valid", 32'(bus.if_id_valid), 32'd1);
    check("redir_slot_instr", bus.if_id_instr, mem[6]);
`else
    check("redir_squash_valid", 32'(bus.if_id_valid), 32'd0);
    check("redir_squash_instr", bus.if_id_instr, 32'h0);
`endif

    // Redirect and stall together: redirect wins.
    do_cycle(0, 1, 1, 32'h40);
    check("redir_stall_addr", bus.imem_addr, 32'h40);

    // Run off the end of memory.
    guard = 0;
    while (m_pc != LIMIT && guard < 200) begin
      do_cycle(0, 0, 0, 0);
      guard++;
    end
    check("reach_limit_addr", bus.imem_addr, LIMIT);
    do_cycle(0, 0, 0, 0);
    check("halt_flag", 32'(bus.halted), 32'd1);
    check("halt_valid", 32'(bus.if_id_valid), 32'd0);
    do_cycle(0, 1, 0, 0);
    check("halt_hold_addr", bus.imem_addr, LIMIT);
    do_cycle(0, 0, 1, 32'h400);
    check("halt_oor_redir", 32'(bus.halted), 32'd1);
    do_cycle(0, 0, 1, 32'h10);
    check("halt_exit_flag", 32'(bus.halted), 32'd0);
    check("halt_exit_addr", bus.imem_addr, 32'h10);

    // Reset during a stall.
    do_cycle(0, 1, 0, 0);
    do_cycle(1, 1, 1, 32'h80);
    check_reset_values("rst_stall");

    // Reset while halted.
    do_cycle(0, 0, 1, 32'h1F0);
    for (int i = 0; i < 5; i++) do_cycle(0, 0, 0, 0);
    check("halt2_flag", 32'(bus.halted), 32'd1);
    do_cycle(1, 0, 0, 0);
    check_reset_values("rst_halt");

    // Randomized traffic, including out-of-range targets and resets.
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 99) < 1);
      s = ($urandom_range(0, 99) < 20);
      d = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 9) == 0) t = $urandom;
      else                           t = 32'($urandom_range(0, 32'h240));
      do_cycle(r, s, d, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
